// File: rtl/freq_meter.sv
// freq_meter: gated edge count scaled to Hz, rise-to-rise period in clk_In cycles, and signal-loss detection.
module freq_meter #(
  parameter int CLK_FREQ = 12090000,
  parameter int GATE_HZ  = 10,
  parameter int CNT_W    = 24
) (
  input  logic             clk_In,
  input  logic             rst_n,
  input  logic             sig_In,
  output logic [CNT_W-1:0] freq_Hz,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_cyc,
  output logic             period_valid,
  output logic             sig_lost,
  output logic             overflow
);
  localparam int WIN = CLK_FREQ / GATE_HZ;
  localparam int TW  = $clog2(WIN + 1);
  localparam int PW  = CNT_W + $clog2(GATE_HZ + 1) + 1;
  localparam int XW  = TW > CNT_W ? TW : CNT_W;
  localparam logic [CNT_W-1:0] MAX = '1;

  typedef enum logic {IDLE, ARMED} state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q, rise, win_end, clamp;
  logic [TW-1:0]    win_cnt_q, win_cnt_d, per_cnt_q, per_cnt_d, idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d, freq_q, freq_d, period_q, period_d;
  logic             mv_q, mv_d, pv_q, pv_d, lost_q, lost_d, ovf_q, ovf_d;
  logic [PW-1:0]    prod;

  assign rise    = s2_q & ~s3_q;
  assign win_end = win_cnt_q == TW'(WIN - 1);
  // an edge registered on the closing cycle still belongs to the closing window
  assign prod    = (PW'(edge_cnt_q) + PW'(rise)) * PW'(GATE_HZ);
  assign clamp   = (&edge_cnt_q) | (|prod[PW-1:CNT_W]);

  always_comb begin
    win_cnt_d  = win_end ? '0 : win_cnt_q + 1'b1;
    edge_cnt_d = win_end ? '0 : edge_cnt_q + CNT_W'(rise & ~&edge_cnt_q);
    mv_d       = win_end;
    freq_d     = win_end ? (clamp ? MAX : prod[CNT_W-1:0]) : freq_q;
    ovf_d      = ovf_q | (win_end & clamp);
    state_d    = state_q;
    per_cnt_d  = per_cnt_q;
    idle_cnt_d = idle_cnt_q;
    period_d   = period_q;
    pv_d       = 1'b0;
    lost_d     = lost_q;
    if (state_q == IDLE) begin
      if (rise) begin
        state_d   = ARMED;
        per_cnt_d = TW'(1);
        lost_d    = 1'b0;
      end else if (idle_cnt_q == TW'(WIN - 1)) lost_d = 1'b1;
      else idle_cnt_d = idle_cnt_q + 1'b1;
    end else if (rise) begin
      per_cnt_d = TW'(1);
      pv_d      = 1'b1;
      period_d  = XW'(per_cnt_q) > XW'(MAX) ? MAX : CNT_W'(per_cnt_q);
    end else if (per_cnt_q == TW'(WIN)) begin
      state_d = IDLE;
      lost_d  = 1'b1;
    end else per_cnt_d = per_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_In or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      state_q    <= IDLE;
      win_cnt_q  <= '0;
      per_cnt_q  <= '0;
      idle_cnt_q <= '0;
      edge_cnt_q <= '0;
      freq_q     <= '0;
      period_q   <= '0;
      mv_q       <= 1'b0;
      pv_q       <= 1'b0;
      lost_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s1_q       <= sig_In;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      per_cnt_q  <= per_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      freq_q     <= freq_d;
      period_q   <= period_d;
      mv_q       <= mv_d;
      pv_q       <= pv_d;
      lost_q     <= lost_d;
      ovf_q      <= ovf_d;
    end
  end

  assign freq_Hz      = freq_q;
  assign meas_valid   = mv_q;
  assign period_cyc   = period_q;
  assign period_valid = pv_q;
  assign sig_lost     = lost_q;
  assign overflow     = ovf_q;
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: table vectors, corner sequences and random toggling checked against an edge-timeline model.
module tb_freq_meter;
  localparam int CF = 1000, GH = 10, CW = 12, OW = 6, WIN = CF / GH;
  localparam int FMAX = (1 << CW) - 1;

  typedef struct { int half; int per; int freq; bit lost; } vec_t;

  logic clk_In = 1'b0, rst_n = 1'b0, sig_In = 1'b0;
  logic [CW-1:0] freq_Hz, period_cyc;
  logic meas_valid, period_valid, sig_lost, overflow;
  logic o_rst_n = 1'b0, o_sig = 1'b0;
  logic [OW-1:0] o_freq, o_per;
  logic o_mv, o_pv, o_lost, o_ovf;

  int nvec = 0, nmis = 0, half = 0, ph = 0;
  vec_t tv[7];

  bit q[$];
  bit smp, e_mv, e_pv, e_lost, e_ovf;
  int t, last_rise, ref_t, nr, e_freq, e_per;

  always #5 clk_In = ~clk_In;

  freq_meter #(.CLK_FREQ(CF), .GATE_HZ(GH), .CNT_W(CW)) dut (
    .clk_In(clk_In), .rst_n(rst_n), .sig_In(sig_In), .freq_Hz(freq_Hz), .meas_valid(meas_valid),
    .period_cyc(period_cyc), .period_valid(period_valid), .sig_lost(sig_lost), .overflow(overflow));

  freq_meter #(.CLK_FREQ(CF), .GATE_HZ(GH), .CNT_W(OW)) odut (
    .clk_In(clk_In), .rst_n(o_rst_n), .sig_In(o_sig), .freq_Hz(o_freq), .meas_valid(o_mv),
    .period_cyc(o_per), .period_valid(o_pv), .sig_lost(o_lost), .overflow(o_ovf));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk_In);
      if (half > 0) begin
        ph++;
        if (ph >= half) begin
          sig_In = ~sig_In;
          ph = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_In);
    rst_n = 1'b0;
    half = 0;
    ph = 0;
    sig_In = 1'b0;
    @(negedge clk_In);
    rst_n = 1'b1;
  endtask

  task automatic wait_mv();
    int n = 0;
    do begin
      run(1);
      n++;
    end while (!meas_valid && n < 2 * WIN);
    if (!meas_valid) chk("meas_valid timeout", meas_valid, 1);
  endtask

  // Model: rises are 0->1 steps of the per-edge sample timeline, registered two edges later.
  initial forever begin
    @(posedge clk_In);
    smp = sig_In;
    #1;
    if (!rst_n) begin
      q = '{1'b0, 1'b0, 1'b0};
      t = 0; last_rise = -1; ref_t = 0; nr = 0;
      e_freq = 0; e_per = 0; e_mv = 0; e_pv = 0; e_lost = 0; e_ovf = 0;
    end else begin
      t++;
      q.push_back(smp);
      e_pv = 0;
      e_mv = (t % WIN == 0);
      if (q[1] && !q[0]) begin
        nr++;
        if (last_rise >= 0 && t - last_rise <= WIN) begin
          e_pv = 1;
          e_per = t - last_rise;
        end
        last_rise = t;
        ref_t = t;
      end
      e_lost = (t - ref_t >= WIN);
      if (e_mv) begin
        if (nr * GH > FMAX) e_ovf = 1;
        e_freq = (nr * GH > FMAX) ? FMAX : nr * GH;
        nr = 0;
      end
      void'(q.pop_front());
    end
    chk("model meas_valid", meas_valid, e_mv);
    chk("model freq_Hz", freq_Hz, e_freq);
    chk("model period_valid", period_valid, e_pv);
    chk("model period_cyc", period_cyc, e_per);
    chk("model sig_lost", sig_lost, e_lost);
    chk("model overflow", overflow, e_ovf);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lastpv, first_lost, hold;
    tv = '{'{1, 2, 500, 1'b0}, '{2, 4, 250, 1'b0}, '{5, 10, 100, 1'b0}, '{10, 20, 50, 1'b0},
           '{25, 50, 20, 1'b0}, '{50, 100, 10, 1'b0}, '{0, 0, 0, 1'b1}};

    for (int i = 0; i < 8; i++) begin
      @(negedge clk_In);
      sig_In = ~sig_In;
    end
    chk("rst freq_Hz", freq_Hz, 0);
    chk("rst meas_valid", meas_valid, 0);
    chk("rst period_cyc", period_cyc, 0);
    chk("rst period_valid", period_valid, 0);
    chk("rst sig_lost", sig_lost, 0);
    chk("rst overflow", overflow, 0);
    sig_In = 1'b0;
    @(negedge clk_In);
    rst_n = 1'b1;
    run(99);
    chk("first mv early", meas_valid, 0);
    run(1);
    chk("first mv at 100", meas_valid, 1);
    chk("idle sig_lost", sig_lost, 1);
    run(1);
    chk("mv one cycle", meas_valid, 0);

    foreach (tv[i]) begin
      do_reset();
      half = tv[i].half;
      run(350);
      wait_mv();
      chk("tbl freq", freq_Hz, tv[i].freq);
      chk("tbl period", period_cyc, tv[i].per);
      chk("tbl lost", sig_lost, tv[i].lost);
    end

    do_reset();
    run(97);
    sig_In = 1'b1;
    run(3);
    chk("boundary mv", meas_valid, 1);
    chk("boundary freq", freq_Hz, 10);
    run(100);
    chk("boundary next mv", meas_valid, 1);
    chk("boundary next freq", freq_Hz, 0);

    do_reset();
    half = 5;
    lastpv = -1;
    first_lost = -1;
    for (int c = 1; c <= 500 && first_lost < 0; c++) begin
      if (c == 300) begin
        half = 0;
        sig_In = 1'b0;
      end
      run(1);
      if (period_valid) lastpv = c;
      if (sig_lost) first_lost = c;
    end
    chk("loss delay", first_lost - lastpv, WIN);
    chk("loss flag", sig_lost, 1);
    chk("loss period hold", period_cyc, 10);
    sig_In = 1'b1;
    run(3);
    chk("recover lost", sig_lost, 0);
    chk("recover no pv", period_valid, 0);
    sig_In = 1'b0;
    run(6);
    sig_In = 1'b1;
    run(3);
    chk("recover pv", period_valid, 1);
    chk("recover period", period_cyc, 9);

    do_reset();
    half = 5;
    run(357);
    chk("pre-reset freq", freq_Hz, 100);
    chk("pre-reset period", period_cyc, 10);
    rst_n = 1'b0;
    #1;
    chk("async freq", freq_Hz, 0);
    chk("async period", period_cyc, 0);
    chk("async mv", meas_valid, 0);
    chk("async pv", period_valid, 0);
    chk("async lost", sig_lost, 0);
    chk("async ovf", overflow, 0);
    run(1);
    rst_n = 1'b1;
    run(99);
    chk("post-reset mv early", meas_valid, 0);
    run(1);
    chk("post-reset mv", meas_valid, 1);

    do_reset();
    repeat (400) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      hold = ($urandom_range(0, 9) == 0) ? $urandom_range(90, 130) : $urandom_range(1, 12);
      sig_In = ~sig_In;
      run(hold);
    end

    @(negedge clk_In);
    o_rst_n = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      o_sig = (c <= 200) ? (c % 2 == 1) : ((c / 10) % 2 == 1);
      @(negedge clk_In);
      if (c == 99) chk("ovf not yet", o_ovf, 0);
      if (c == 100) begin
        chk("ovf mv", o_mv, 1);
        chk("ovf freq", o_freq, 63);
        chk("ovf flag", o_ovf, 1);
      end
      if (c == 199) chk("ovf pv", o_pv, 1);
      if (c == 200) chk("ovf period", o_per, 2);
      if (c == 400) begin
        chk("ovf slow mv", o_mv, 1);
        chk("ovf slow freq", o_freq, 50);
        chk("ovf sticky", o_ovf, 1);
        chk("ovf slow period", o_per, 20);
        chk("ovf lost", o_lost, 0);
      end
    end
    o_rst_n = 1'b0;
    #1;
    chk("ovf reset flag", o_ovf, 0);
    chk("ovf reset freq", o_freq, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
